// File: rtl/alu_decoder.sv
// RV32I ALU-control decoder.
// Maps opcode/funct3/funct7 to a 4-bit ALU operation and flags illegal field combinations.
// Both results are also available one cycle later through a synchronously reset register.
module alu_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] alu_control_q,
  output logic       illegal_op_q
);

  // ALU operation encodings
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSlt   = 4'b0101;
  localparam logic [3:0] AluSltu  = 4'b0110;
  localparam logic [3:0] AluSll   = 4'b0111;
  localparam logic [3:0] AluSrl   = 4'b1000;
  localparam logic [3:0] AluSra   = 4'b1001;
  localparam logic [3:0] AluLui   = 4'b1010;
  localparam logic [3:0] AluAuipc = 4'b1011;

  // RV32I major opcodes
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  // funct7 values accepted on R-type and shift-immediate encodings
  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  // Shared register/immediate arithmetic table; alt selects SUB/SRA variants.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = AluAdd;
    unique case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      3'b111:  op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

  logic f7_is_base;
  logic f7_is_alt;

  assign f7_is_base = (funct7 == F7Base);
  assign f7_is_alt  = (funct7 == F7Alt);

  // ALU operation decode; only funct7[5] steers the result.
  always_comb begin
    alu_control = AluAdd;
    case (opcode)
      OpcOp:     alu_control = arith_op(funct3, funct7[5]);
      // ADDI has no SUB form, so bit 5 only matters for the right shifts.
      OpcOpImm:  alu_control = arith_op(funct3, funct7[5] & (funct3 == 3'b101));
      OpcLoad,
      OpcStore,
      OpcJal,
      OpcJalr:   alu_control = AluAdd;
      OpcBranch: alu_control = AluSub;
      OpcLui:    alu_control = AluLui;
      OpcAuipc:  alu_control = AluAuipc;
      default:   alu_control = AluAdd;
    endcase
  end

  // Illegal-encoding detection; independent of the ALU decode above.
  always_comb begin
    illegal_op = 1'b0;
    case (opcode)
      OpcOp: begin
        if (!f7_is_base && !f7_is_alt) begin
          illegal_op = 1'b1;
        end else if (f7_is_alt && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          illegal_op = 1'b1;
        end
      end
      OpcOpImm: begin
        if ((funct3 == 3'b001) && !f7_is_base) begin
          illegal_op = 1'b1;
        end else if ((funct3 == 3'b101) && !f7_is_base && !f7_is_alt) begin
          illegal_op = 1'b1;
        end
      end
      OpcLoad: begin
        illegal_op = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpcStore: begin
        illegal_op = (funct3 >= 3'b011);
      end
      OpcBranch: begin
        illegal_op = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OpcJalr: begin
        illegal_op = (funct3 != 3'b000);
      end
      OpcAuipc,
      OpcLui,
      OpcJal,
      OpcMiscMem,
      OpcSystem: begin
        illegal_op = 1'b0;
      end
      default: begin
        illegal_op = 1'b1;
      end
    endcase
  end

  // One-cycle registered copy of both decode results; reset forces ADD / legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control_q <= AluAdd;
      illegal_op_q  <= 1'b0;
    end else begin
      alu_control_q <= alu_control;
      illegal_op_q  <= illegal_op;
    end
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Directed and swept checks of the ALU-control decoder, combinational and registered paths.
module tb_alu_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_control;
  logic       illegal_op;
  logic [3:0] alu_control_q;
  logic       illegal_op_q;

  int n_total;
  int n_bad;

  alu_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_control   (alu_control),
    .illegal_op    (illegal_op),
    .alu_control_q (alu_control_q),
    .illegal_op_q  (illegal_op_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one instruction's fields and check both combinational outputs.
  task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [3:0] exp_alu, input logic exp_ill);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    #1;
    check_eq({tag, "_alu"}, 32'(alu_control), 32'(exp_alu));
    check_eq({tag, "_ill"}, 32'(illegal_op), 32'(exp_ill));
  endtask

  // Independent reference model, written as plain if-chains.
  function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] r;
    r = 4'b0000;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      if (f3 == 3'd0) r = (op == 7'b0110011 && f7[5]) ? 4'b0001 : 4'b0000;
      else if (f3 == 3'd1) r = 4'b0111;
      else if (f3 == 3'd2) r = 4'b0101;
      else if (f3 == 3'd3) r = 4'b0110;
      else if (f3 == 3'd4) r = 4'b0100;
      else if (f3 == 3'd5) r = f7[5] ? 4'b1001 : 4'b1000;
      else if (f3 == 3'd6) r = 4'b0011;
      else r = 4'b0010;
    end else if (op == 7'b1100011) r = 4'b0001;
    else if (op == 7'b0110111) r = 4'b1010;
    else if (op == 7'b0010111) r = 4'b1011;
    return r;
  endfunction

  function automatic logic ref_ill(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7);
    logic f7ok;
    f7ok = (f7 == 7'h00) || (f7 == 7'h20);
    if (op == 7'b0110011) return !f7ok || (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
    if (op == 7'b0010011) return (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !f7ok);
    if (op == 7'b0000011) return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
    if (op == 7'b0100011) return f3 > 3'd2;
    if (op == 7'b1100011) return f3 == 3'd2 || f3 == 3'd3;
    if (op == 7'b1100111) return f3 != 3'd0;
    if (op == 7'b0010111 || op == 7'b0110111 || op == 7'b1101111 ||
        op == 7'b0001111 || op == 7'b1110011) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    opcode  = 7'b0000000;
    funct3  = 3'b000;
    funct7  = 7'b0000000;

    // Reset state of the registered outputs
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_alu_q", 32'(alu_control_q), 32'h0);
    check_eq("rst_ill_q", 32'(illegal_op_q), 32'h0);

    // Directed combinational vectors
    vec("op_add",    7'b0110011, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    vec("op_sub",    7'b0110011, 3'b000, 7'b0100000, 4'b0001, 1'b0);
    vec("op_sll",    7'b0110011, 3'b001, 7'b0000000, 4'b0111, 1'b0);
    vec("op_srl",    7'b0110011, 3'b101, 7'b0000000, 4'b1000, 1'b0);
    vec("op_sra",    7'b0110011, 3'b101, 7'b0100000, 4'b1001, 1'b0);
    vec("imm_add",   7'b0010011, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    vec("imm_srl",   7'b0010011, 3'b101, 7'b0000000, 4'b1000, 1'b0);
    vec("imm_sra",   7'b0010011, 3'b101, 7'b0100000, 4'b1001, 1'b0);
    vec("imm_add_b5", 7'b0010011, 3'b000, 7'b0100000, 4'b0000, 1'b0);
    vec("load",      7'b0000011, 3'b010, 7'b0000000, 4'b0000, 1'b0);
    vec("store",     7'b0100011, 3'b010, 7'b0000000, 4'b0000, 1'b0);
    vec("branch",    7'b1100011, 3'b000, 7'b0000000, 4'b0001, 1'b0);
    vec("lui",       7'b0110111, 3'b000, 7'b0000000, 4'b1010, 1'b0);
    vec("auipc",     7'b0010111, 3'b000, 7'b0000000, 4'b1011, 1'b0);
    vec("jal",       7'b1101111, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    vec("jalr",      7'b1100111, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    vec("ill_op_f7", 7'b0110011, 3'b000, 7'b0000001, 4'b0000, 1'b1);
    vec("ill_slli",  7'b0010011, 3'b001, 7'b0100000, 4'b0111, 1'b1);
    vec("ill_jalr",  7'b1100111, 3'b001, 7'b0000000, 4'b0000, 1'b1);
    vec("ill_opc",   7'b1111111, 3'b000, 7'b0000000, 4'b0000, 1'b1);

    // Registered path: reset held with SUB applied
    vec("rp_sub", 7'b0110011, 3'b000, 7'b0100000, 4'b0001, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rp_rst_alu_q", 32'(alu_control_q), 32'h0);
      check_eq("rp_rst_ill_q", 32'(illegal_op_q), 32'h0);
      check_eq("rp_rst_alu", 32'(alu_control), 32'h1);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rp_rel_alu_q", 32'(alu_control_q), 32'h1);
    vec("rp_lui", 7'b0110111, 3'b000, 7'b0000000, 4'b1010, 1'b0);
    check_eq("rp_lui_hold_q", 32'(alu_control_q), 32'h1);
    @(posedge clk);
    #1;
    check_eq("rp_lui_alu_q", 32'(alu_control_q), 32'hA);

    // Sweep of opcode x funct3 x funct7[5], other funct7 bits sometimes randomised
    for (int o = 0; o < 128; o++) begin
      for (int f = 0; f < 8; f++) begin
        for (int b = 0; b < 2; b++) begin
          logic [6:0] f7;
          logic [3:0] ea;
          logic       ei;
          f7 = 7'($urandom);
          if ($urandom_range(0, 2) != 0) f7 = 7'b0000000;
          f7[5] = b[0];
          opcode = o[6:0];
          funct3 = f[2:0];
          funct7 = f7;
          ea = ref_alu(o[6:0], f[2:0], f7);
          ei = ref_ill(o[6:0], f[2:0], f7);
          #1;
          check_eq($sformatf("sw_alu o=%0h f3=%0d f7=%0h", o, f, f7), 32'(alu_control), 32'(ea));
          check_eq($sformatf("sw_ill o=%0h f3=%0d f7=%0h", o, f, f7), 32'(illegal_op), 32'(ei));
          @(posedge clk);
          #1;
          check_eq($sformatf("sw_alu_q o=%0h f3=%0d f7=%0h", o, f, f7), 32'(alu_control_q),
                   32'(ea));
          check_eq($sformatf("sw_ill_q o=%0h f3=%0d f7=%0h", o, f, f7), 32'(illegal_op_q),
                   32'(ei));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- Combinational RV32I ALU-control decoder in the single-cycle core's control path, beside the main decoder.
- Maps the instruction fields opcode, funct3 and funct7 to a 4-bit ALU operation code that drives the ALU select.
- Also flags illegal field combinations.
- Provides a one-cycle registered copy of both outputs for pipelined or debug consumers.

Parameters:
- None. All encodings are fixed localparams.

Ports:
- clk  input  1  system clock; registered outputs only.
- rst  input  1  reset; synchronous, active-high.
- opcode  input  7  instr[6:0].
- funct3  input  3  instr[14:12].
- funct7  input  7  instr[31:25].
- alu_control  output  4  combinational ALU op.
- illegal_op  output  1  combinational: field combination not a legal RV32I encoding.
- alu_control_q  output  4  alu_control registered.
- illegal_op_q  output  1  illegal_op registered.

Behaviour:
- ALU codes:
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101
  - SLTU=0110, SLL=0111, SRL=1000, SRA=1001, LUI=1010, AUIPC=1011
- Opcodes:
  - LOAD=0000011, OP_IMM=0010011, AUIPC=0010111, STORE=0100011, OP=0110011
  - LUI=0110111, BRANCH=1100011, JAL=1101111, JALR=1100111
  - MISC_MEM=0001111, SYSTEM=1110011
- alu_control is purely combinational, zero latency, with no clock dependence. Decode:
  - OP, by funct3:
    - 000 → SUB if funct7[5], else ADD
    - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
    - 101 → SRA if funct7[5], else SRL
    - 110 → OR; 111 → AND
  - OP_IMM: same table, except funct3 000 is always ADD; funct7[5] is ignored for ADDI.
  - LOAD, STORE, JALR, JAL → ADD (address or target computation).
  - BRANCH → SUB for every funct3.
  - LUI → LUI. AUIPC → AUIPC.
  - Any other opcode, including MISC_MEM and SYSTEM → ADD.
- Only funct7[5] steers alu_control. Other funct7 bits never change alu_control; they affect illegal_op only.
- illegal_op = 1 when any of the following holds:
  - OP: funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101}.
  - OP_IMM: funct3=001 with funct7≠0000000; or funct3=101 with funct7 ∉ {0000000, 0100000}.
  - LOAD: funct3 ∈ {011, 110, 111}.
  - STORE: funct3 ≥ 011.
  - BRANCH: funct3 ∈ {010, 011}.
  - JALR: funct3≠000.
  - Opcode not in the opcode list above.
- illegal_op never alters alu_control; the decode above still applies (e.g. an unknown opcode gives ADD with illegal_op=1).
- Registered outputs:
  - On each rising clk: if rst, alu_control_q←0000 (ADD) and illegal_op_q←0.
  - Otherwise alu_control_q←alu_control and illegal_op_q←illegal_op.
  - Latency is exactly 1 cycle; no enable and no hold.
- Reset asserted mid-stream clears only the registered outputs. The combinational outputs keep tracking the inputs during reset.
- X or Z inputs are don't-care; known inputs must yield fully known outputs (no latches, complete case defaults).

Test Plan:
- OP funct3=000: funct7=0000000 → ADD 0000; funct7=0100000 → SUB 0001. OP funct3=001 → SLL 0111. OP funct3=101: funct7=0000000 → SRL 1000; funct7=0100000 → SRA 1001. All with illegal_op=0.
- OP_IMM: funct3=000 → ADD; funct3=101 with funct7=0000000 → SRL; funct3=101 with funct7=0100000 → SRA. OP_IMM funct3=000 with funct7=0100000 → still ADD, illegal_op=0.
- Non-ALU opcodes:
  - LOAD f3=010 → ADD; STORE f3=010 → ADD; BRANCH f3=000 → SUB.
  - LUI → 1010; AUIPC → 1011; JAL → ADD; JALR f3=000 → ADD.
  - All with illegal_op=0.
- Illegal cases:
  - OP funct3=000 with funct7=0000001 → alu_control=ADD, illegal_op=1.
  - OP_IMM funct3=001 with funct7=0100000 → SLL, illegal_op=1.
  - JALR f3=001 → ADD, illegal_op=1.
  - opcode=1111111 → ADD, illegal_op=1.
- Registered path:
  - rst=1 for 2 cycles with OP/SUB applied → alu_control_q=0000, illegal_op_q=0, while alu_control=0001.
  - Release rst → next edge gives alu_control_q=0001.
  - Change the input to LUI → alu_control_q=1010 one cycle later.
- Exhaustive sweep of all opcode×funct3×funct7[5] combinations (and random funct7) against a reference model, checking both combinational outputs and the 1-cycle-delayed registered outputs.
